// File: rtl/alu_mult_div.sv
// alu_mult_div: registered, handshaked MIPS EX-stage ALU.
// Logic and arithmetic ops finish in one cycle. MULT/MULTU take WIDTH+2 cycles
// using a shift-add multiplier that handles one bit per cycle.
// Optional build macro ALU_DIV_EN adds DIV/DIVU, implemented as a restoring
// divider that reuses the multiplier's shift registers. When the macro is not
// defined, opcodes 1010/1011 are treated as undefined and div_zero is tied low.
module alu_mult_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUcontrol,
    input  logic [WIDTH-1:0] entradaA,
    input  logic [WIDTH-1:0] entradaB,
    output logic [WIDTH-1:0] ALUsaida,
    output logic             Zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
`endif

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   sh;
    logic [WIDTH-1:0]   opnd;
    logic               neg_q;
    logic [WIDTH-1:0]   quick_res;
    logic               is_mul_op;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   acc_n;
    logic [WIDTH-1:0]   sh_n;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
`ifdef ALU_DIV_EN
    logic               is_div_op;
    logic               is_div;
    logic               neg_r;
    logic               div_zero_q;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;

    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

    // Decode the opcode: compute single-cycle results and classify iterative ops.
    always_comb begin
        quick_res = '0;
        is_mul_op = 1'b0;
        op_signed = 1'b0;
`ifdef ALU_DIV_EN
        is_div_op = 1'b0;
`endif
        case (ALUcontrol)
            OP_AND:   quick_res = entradaA & entradaB;
            OP_OR:    quick_res = entradaA | entradaB;
            OP_ADD:   quick_res = entradaA + entradaB;
            OP_SUB:   quick_res = entradaA - entradaB;
            OP_SLT:   quick_res = {{(WIDTH-1){1'b0}}, ($signed(entradaA) < $signed(entradaB))};
            OP_SLTU:  quick_res = {{(WIDTH-1){1'b0}}, (entradaA < entradaB)};
            OP_NOR:   quick_res = ~(entradaA | entradaB);
            OP_XOR:   quick_res = entradaA ^ entradaB;
            OP_MFHI:  quick_res = hi;
            OP_MFLO:  quick_res = lo;
            OP_MULT:  begin is_mul_op = 1'b1; op_signed = 1'b1; end
            OP_MULTU: is_mul_op = 1'b1;
`ifdef ALU_DIV_EN
            OP_DIV:   begin is_div_op = 1'b1; op_signed = 1'b1; end
            OP_DIVU:  is_div_op = 1'b1;
`endif
            default:  quick_res = '0;
        endcase
    end

    // Signed ops iterate on magnitudes; the signs are reapplied in FIX.
    always_comb begin
        a_neg = op_signed & entradaA[WIDTH-1];
        b_neg = op_signed & entradaB[WIDTH-1];
        a_abs = a_neg ? (~entradaA + 1'b1) : entradaA;
        b_abs = b_neg ? (~entradaB + 1'b1) : entradaB;
    end

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        mul_sum = {1'b0, acc} + {1'b0, opnd};
        if (sh[0]) begin
            {acc_n, sh_n} = {mul_sum, sh[WIDTH-1:1]};
        end else begin
            {acc_n, sh_n} = {1'b0, acc, sh[WIDTH-1:1]};
        end
`ifdef ALU_DIV_EN
        div_shift = {acc, sh[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                acc_n = div_diff[WIDTH-1:0];
                sh_n  = {sh[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = div_shift[WIDTH-1:0];
                sh_n  = {sh[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Sign correction applied to the finished magnitude result.
    always_comb begin
        prod_fix = neg_q ? ('0 - {acc, sh}) : {acc, sh};
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
`ifdef ALU_DIV_EN
        if (is_div) begin
            fix_lo = neg_q ? ('0 - sh) : sh;
            fix_hi = neg_r ? ('0 - acc) : acc;
        end
`endif
    end

    // Control FSM together with the iteration datapath and the result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            sh       <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            ALUsaida <= '0;
            Zero     <= 1'b1;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef ALU_DIV_EN
            is_div     <= 1'b0;
            neg_r      <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
`ifdef ALU_DIV_EN
                        div_zero_q <= 1'b0;
                        is_div     <= is_div_op;
                        neg_r      <= a_neg;
`endif
                        neg_q <= a_neg ^ b_neg;
                        acc   <= '0;
                        cnt   <= CNT_W'(WIDTH);
                        if (is_mul_op) begin
                            sh    <= b_abs;
                            opnd  <= a_abs;
                            busy  <= 1'b1;
                            state <= S_ITER;
                        end
`ifdef ALU_DIV_EN
                        else if (is_div_op && (entradaB == '0)) begin
                            hi         <= entradaA;
                            lo         <= '1;
                            ALUsaida   <= '1;
                            Zero       <= 1'b0;
                            div_zero_q <= 1'b1;
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end else if (is_div_op) begin
                            sh    <= a_abs;
                            opnd  <= b_abs;
                            busy  <= 1'b1;
                            state <= S_ITER;
                        end
`endif
                        else begin
                            ALUsaida <= quick_res;
                            Zero     <= (quick_res == '0);
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_ITER: begin
                    acc <= acc_n;
                    sh  <= sh_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi       <= fix_hi;
                    lo       <= fix_lo;
                    ALUsaida <= fix_lo;
                    Zero     <= (fix_lo == '0);
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_div.sv
// tb_alu_mult_div: scoreboard bench for alu_mult_div (WIDTH=32).
// Expected results come from a plain-arithmetic reference model; a monitor
// pops the scoreboard whenever done pulses. Honours ALU_DIV_EN like the RTL.
module tb_alu_mult_div;

    localparam int WIDTH = 32;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [3:0]        ALUcontrol;
    logic [WIDTH-1:0]  entradaA;
    logic [WIDTH-1:0]  entradaB;
    logic [WIDTH-1:0]  ALUsaida;
    logic              Zero;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;
    logic              busy;
    logic              done;
    logic              div_zero;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] res;
        logic        zero;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          startCyc;
    } expEntry_t;

    expEntry_t   sbq[$];
    expEntry_t   monEntry;
    logic [31:0] mHi;
    logic [31:0] mLo;
    int          cyc;
    int          compared;
    int          mismatched;

    alu_mult_div #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ALUcontrol (ALUcontrol),
        .entradaA   (entradaA),
        .entradaB   (entradaB),
        .ALUsaida   (ALUsaida),
        .Zero       (Zero),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string opName(input logic [3:0] op);
        case (op)
            4'b0000: return "AND";
            4'b0001: return "OR";
            4'b0010: return "ADD";
            4'b0110: return "SUB";
            4'b0111: return "SLT";
            4'b0011: return "SLTU";
            4'b1100: return "NOR";
            4'b0100: return "XOR";
            4'b1101: return "MFHI";
            4'b1110: return "MFLO";
            4'b1000: return "MULT";
            4'b1001: return "MULTU";
            4'b1010: return "DIV";
            4'b1011: return "DIVU";
            default: return "UNDEF";
        endcase
    endfunction

    // Reference model: 64-bit integer arithmetic on the architectural rules.
    function automatic void refModel(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output expEntry_t e);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.op = op; e.res = '0; e.hi = mHi; e.lo = mLo; e.dz = 1'b0; e.lat = 1; e.startCyc = 0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
            4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'b0011: e.res = (a < b) ? 32'd1 : 32'd0;
            4'b1100: e.res = ~(a | b);
            4'b0100: e.res = a ^ b;
            4'b1101: e.res = mHi;
            4'b1110: e.res = mLo;
            4'b1000: begin
                p = sa * sb;
                e.hi = p[63:32]; e.lo = p[31:0]; e.res = p[31:0]; e.lat = WIDTH + 2;
            end
            4'b1001: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32]; e.lo = p[31:0]; e.res = p[31:0]; e.lat = WIDTH + 2;
            end
`ifdef ALU_DIV_EN
            4'b1010, 4'b1011: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = '1; e.res = '1; e.dz = 1'b1; e.lat = 1;
                end else begin
                    if (op == 4'b1010) begin
                        q = sa / sb; r = sa % sb;
                    end else begin
                        q = {32'b0, a} / {32'b0, b}; r = {32'b0, a} % {32'b0, b};
                    end
                    e.lo = q[31:0]; e.hi = r[31:0]; e.res = q[31:0]; e.lat = WIDTH + 2;
                end
            end
`endif
            default: e.res = '0;
        endcase
        e.zero = (e.res == 32'd0);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse retires one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected done: got done=1, expected no pending op (t=%0t)", $time);
            end else begin
                monEntry = sbq.pop_front();
                checkOutput({opName(monEntry.op), " ALUsaida"}, 64'(ALUsaida), 64'(monEntry.res));
                checkOutput({opName(monEntry.op), " Zero"}, 64'(Zero), 64'(monEntry.zero));
                checkOutput({opName(monEntry.op), " hi"}, 64'(hi), 64'(monEntry.hi));
                checkOutput({opName(monEntry.op), " lo"}, 64'(lo), 64'(monEntry.lo));
                checkOutput({opName(monEntry.op), " div_zero"}, 64'(div_zero), 64'(monEntry.dz));
                checkOutput({opName(monEntry.op), " latency"}, 64'(cyc - monEntry.startCyc + 1),
                            64'(monEntry.lat));
            end
        end
    end

    task automatic checkReset(input string tag);
        checkOutput({tag, " ALUsaida"}, 64'(ALUsaida), 64'd0);
        checkOutput({tag, " Zero"}, 64'(Zero), 64'd1);
        checkOutput({tag, " hi"}, 64'(hi), 64'd0);
        checkOutput({tag, " lo"}, 64'(lo), 64'd0);
        checkOutput({tag, " busy"}, 64'(busy), 64'd0);
        checkOutput({tag, " done"}, 64'(done), 64'd0);
        checkOutput({tag, " div_zero"}, 64'(div_zero), 64'd0);
    endtask

    // Issue one op from IDLE, scramble inputs after the start edge, wait for done.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit pokeBusy, input bit pokeDone);
        expEntry_t e;
        int        busyCyc;
        bit        seen;
        refModel(op, a, b, e);
        ALUcontrol = op; entradaA = a; entradaB = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ALUcontrol = 4'($urandom_range(0, 15));
        entradaA = $urandom;
        entradaB = $urandom;
        e.startCyc = cyc;
        sbq.push_back(e);
        mHi = e.hi;
        mLo = e.lo;
        busyCyc = 0;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busyCyc++;
            if (pokeBusy && i == 4) begin
                start = 1'b1; ALUcontrol = 4'b0010; entradaA = $urandom; entradaB = $urandom;
            end
            if (pokeBusy && i == 5) start = 1'b0;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s timeout: got no done, expected done within 80 cycles", opName(op));
        end
        checkOutput({opName(op), " busy cycles"}, 64'(busyCyc), 64'((e.lat == 1) ? 0 : WIDTH + 1));
        if (pokeDone) begin
            start = 1'b1; ALUcontrol = 4'b0010; entradaA = $urandom; entradaB = $urandom;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected completion before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cyc = 0; compared = 0; mismatched = 0;
        mHi = '0; mLo = '0;
        rst_n = 1'b0; start = 1'b0; ALUcontrol = '0; entradaA = '0; entradaB = '0;
        #12;
        checkReset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed operations");
        applyStimulus(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        applyStimulus(4'b0110, 32'd5, 32'd5, 1'b0, 1'b0);
        applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        applyStimulus(4'b0011, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        applyStimulus(4'b1100, 32'h0F0F_0000, 32'h00F0_F0F0, 1'b0, 1'b0);
        applyStimulus(4'b0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        applyStimulus(4'b1000, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        applyStimulus(4'b1101, 32'h1234, 32'h5678, 1'b0, 1'b0);
        applyStimulus(4'b1110, 32'h1234, 32'h5678, 1'b0, 1'b0);
        applyStimulus(4'b1011, 32'd100, 32'd7, 1'b0, 1'b0);
        applyStimulus(4'b1010, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        applyStimulus(4'b1010, 32'h0000_0ABC, 32'd0, 1'b0, 1'b0);
        applyStimulus(4'b0010, 32'd1, 32'd2, 1'b0, 1'b0);
        applyStimulus(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(4'b0101, 32'hAAAA_5555, 32'h1, 1'b0, 1'b0);

        $display("[TB] start while busy and while in DONE");
        applyStimulus(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        applyStimulus(4'b0001, 32'h00F0_0000, 32'h0000_000F, 1'b0, 1'b1);
        applyStimulus(4'b1110, 32'd0, 32'd0, 1'b0, 1'b0);

        $display("[TB] reset during MULTU iteration");
        ALUcontrol = 4'b1001; entradaA = 32'h1234_5678; entradaB = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("mid-op reset");
        sbq.delete();
        mHi = '0;
        mLo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(4'b1101, 32'd3, 32'd4, 1'b0, 1'b0);
        applyStimulus(4'b1000, 32'd1000, 32'hFFFF_FF00, 1'b0, 1'b0);

        $display("[TB] randomized operations");
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          mode;
            op = 4'($urandom_range(0, 15));
            mode = $urandom_range(0, 4);
            a = $urandom;
            b = $urandom;
            if (mode == 1) begin
                a = $urandom_range(0, 20);
                b = $urandom_range(0, 20);
            end else if (mode == 2) begin
                b = '0;
            end else if (mode == 3) begin
                b = a;
            end else if (mode == 4) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            applyStimulus(op, a, b, 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard drained", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
